// File: rtl/compress_pkg.sv
// Shared constants, width helper and output record for the block-bitmap compressor.
package compress_pkg;

  localparam int H_ACT_DEF = 1280;
  localparam int V_ACT_DEF = 720;
  localparam int BLK_W_DEF = 32;
  localparam int BLK_H_DEF = 10;

  function automatic int sum_width(input int bw, input int bh);
    return $clog2(bw * bh + 1);
  endfunction

  localparam int BX_W_DEF = $clog2(H_ACT_DEF / BLK_W_DEF);
  localparam int BY_W_DEF = $clog2(V_ACT_DEF / BLK_H_DEF);

  // Record handed to the bin buffer / target search at the default geometry.
  typedef struct packed {
    logic                bin;
    logic [BX_W_DEF-1:0] bx;
    logic [BY_W_DEF-1:0] by;
    logic                eof;
  } bin_out_t;

endpackage

// File: rtl/bin_psum_ram.sv
// Per-column partial block sums: synchronous write, asynchronous read at the same index.
module bin_psum_ram #(
  parameter int DEPTH = 40,
  parameter int WIDTH = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bin_block_compress.sv
// Reduces a binary pixel mask stream to a thresholded BLK_W x BLK_H block bitmap,
// plus an upscaled debug bit for HDMI overlay.
module bin_block_compress
  import compress_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF,
  parameter int BLK_W = BLK_W_DEF,
  parameter int BLK_H = BLK_H_DEF,
  localparam int COLS  = H_ACT / BLK_W,
  localparam int ROWS  = V_ACT / BLK_H,
  localparam int SUM_W = sum_width(BLK_W, BLK_H),
  localparam int BX_W  = $clog2(COLS),
  localparam int BY_W  = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vsync,
  input  logic             de,
  input  logic             mask,
  input  logic [SUM_W-1:0] thresh,
  output logic             o_valid,
  output logic             o_bin,
  output logic [BX_W-1:0]  o_bx,
  output logic [BY_W-1:0]  o_by,
  output logic             o_eof,
  output logic             dbg_bin
);

  // Column/row counters carry one extra code so they can saturate past the last block.
  localparam int CX_W = $clog2(COLS + 1);
  localparam int CY_W = $clog2(ROWS + 1);
  localparam int PX_W = $clog2(BLK_W);
  localparam int PY_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  localparam logic [CX_W-1:0] COLS_C = CX_W'(COLS);
  localparam logic [CY_W-1:0] ROWS_C = CY_W'(ROWS);

  logic [PX_W-1:0]  px;
  logic [CX_W-1:0]  bx;
  logic [PY_W-1:0]  py;
  logic [CY_W-1:0]  by;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] thr_q;
  logic [SUM_W-1:0] tot;
  logic [SUM_W-1:0] psum_rd;
  logic             de_d;
  logic             synced;

  logic             in_range;
  logic             blk_end;
  logic             line_last;
  logic             complete;
  logic             psum_we;
  logic             bin_val;
  logic [BX_W-1:0]  col;
  logic [BX_W-1:0]  dbg_col;
  logic [COLS-1:0]  dbg_line;

  assign in_range  = de && !vsync && (bx < COLS_C) && (by < ROWS_C);
  assign blk_end   = (px == PX_W'(BLK_W - 1));
  assign line_last = (py == PY_W'(BLK_H - 1));
  assign complete  = in_range && blk_end && line_last;
  assign psum_we   = in_range && blk_end && !line_last;
  assign col       = bx[BX_W-1:0];
  assign dbg_col   = (bx >= COLS_C) ? BX_W'(COLS - 1) : col;

  // The first line of a block row bypasses the RAM, so stale contents never matter.
  assign tot     = acc + SUM_W'(mask) + ((py == '0) ? '0 : psum_rd);
  assign bin_val = (tot >= thr_q);

  bin_psum_ram #(
    .DEPTH (COLS),
    .WIDTH (SUM_W),
    .AW    (BX_W)
  ) u_psum (
    .clk   (clk),
    .we    (psum_we),
    .addr  (col),
    .wdata (tot),
    .rdata (psum_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      px     <= '0;
      bx     <= '0;
      py     <= '0;
      by     <= '0;
      acc    <= '0;
      de_d   <= 1'b0;
      thr_q  <= '0;
      synced <= 1'b0;
    end else if (vsync) begin
      px     <= '0;
      bx     <= '0;
      py     <= '0;
      by     <= '0;
      acc    <= '0;
      de_d   <= 1'b0;
      thr_q  <= thresh;
      synced <= 1'b1;
    end else begin
      de_d <= de;
      if (de) begin
        if (bx < COLS_C) begin
          if (blk_end) begin
            px <= '0;
            bx <= bx + 1'b1;
          end else begin
            px <= px + 1'b1;
          end
        end
        if (in_range) acc <= blk_end ? '0 : acc + SUM_W'(mask);
      end else if (de_d) begin
        px  <= '0;
        bx  <= '0;
        acc <= '0;
        if (line_last) begin
          py <= '0;
          if (by < ROWS_C) by <= by + 1'b1;
        end else begin
          py <= py + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_bin   <= 1'b0;
      o_bx    <= '0;
      o_by    <= '0;
      o_eof   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_eof   <= 1'b0;
      if (complete && synced) begin
        o_valid <= 1'b1;
        o_bin   <= bin_val;
        o_bx    <= col;
        o_by    <= by[BY_W-1:0];
        o_eof   <= (bx == CX_W'(COLS - 1)) && (by == CY_W'(ROWS - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (complete && synced) dbg_line[col] <= bin_val;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dbg_bin <= 1'b0;
    else       dbg_bin <= de ? dbg_line[dbg_col] : 1'b0;
  end

endmodule

// File: tb/tb_bin_block_compress.sv
// Scoreboard bench for bin_block_compress at 16x8 pixels with 4x2 blocks.
module tb_bin_block_compress;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int BW = 4;
  localparam int BH = 2;
  localparam int NC = H / BW;
  localparam int NR = V / BH;

  logic       clk = 1'b0;
  logic       rstn;
  logic       vsync;
  logic       de;
  logic       mask;
  logic [3:0] thresh;
  logic       o_valid;
  logic       o_bin;
  logic [1:0] o_bx;
  logic [1:0] o_by;
  logic       o_eof;
  logic       dbg_bin;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int bin;
    int bx;
    int by;
    int eof;
    int cyc;
  } exp_t;

  exp_t q[$];
  bit   fmask[V][H];
  int   model_thr;
  bit   model_synced;

  bin_block_compress #(
    .H_ACT (H),
    .V_ACT (V),
    .BLK_W (BW),
    .BLK_H (BH)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .vsync   (vsync),
    .de      (de),
    .mask    (mask),
    .thresh  (thresh),
    .o_valid (o_valid),
    .o_bin   (o_bin),
    .o_bx    (o_bx),
    .o_by    (o_by),
    .o_eof   (o_eof),
    .dbg_bin (dbg_bin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every pulse is matched against the oldest expected block, including its cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_valid", int'(o_valid), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          checkOutput("bin", int'(o_bin), e.bin);
          checkOutput("bx", int'(o_bx), e.bx);
          checkOutput("by", int'(o_by), e.by);
          checkOutput("eof", int'(o_eof), e.eof);
          checkOutput("latency", cyc, e.cyc);
        end
      end else begin
        checkOutput("eof_idle", int'(o_eof), 0);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic d, input logic m);
    vsync = v;
    de    = d;
    mask  = m;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic genMask(input int p);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        case (p)
          0:       fmask[y][x] = 1'b1;
          1:       fmask[y][x] = (x < 4);
          2:       fmask[y][x] = (y == 0 && x < 4) || (y == 1 && x == 0);
          3:       fmask[y][x] = 1'b0;
          4:       fmask[y][x] = (y % 2 == 0);
          default: fmask[y][x] = (x < 4) && (y < 2);
        endcase
      end
    end
  endtask

  // vs_mode: 0 no vsync, 1 vsync in blanking, 2 one-cycle vsync on top of a live pixel.
  task automatic driveFrame(input int vs_mode, input logic [3:0] thr, input logic [3:0] thr_mid,
                            input int stop_y, input int stop_x, input bit chk_dbg);
    int cnt[NR][NC];
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        cnt[r][c] = 0;
        for (int yy = 0; yy < BH; yy++)
          for (int xx = 0; xx < BW; xx++)
            cnt[r][c] += int'(fmask[r*BH+yy][c*BW+xx]);
      end
    end
    if (vs_mode == 1) begin
      thresh = thr;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      thresh = thr_mid;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end else if (vs_mode == 2) begin
      thresh = thr;
      applyStimulus(1'b1, 1'b1, 1'b1);
      thresh = thr_mid;
    end
    if (vs_mode != 0) begin
      model_thr    = int'(thr);
      model_synced = 1'b1;
    end
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (y == stop_y && x == stop_x) return;
        if (model_synced && (x % BW == BW - 1) && (y % BH == BH - 1)) begin
          exp_t e;
          e.bx  = x / BW;
          e.by  = y / BH;
          e.bin = (cnt[e.by][e.bx] >= model_thr) ? 1 : 0;
          e.eof = (e.bx == NC - 1 && e.by == NR - 1) ? 1 : 0;
          e.cyc = cyc + 1;
          q.push_back(e);
        end
        applyStimulus(1'b0, 1'b1, fmask[y][x]);
        if (chk_dbg && y >= 2) checkOutput("dbg_px", int'(dbg_bin), (y < 4 && x < 4) ? 1 : 0);
      end
      for (int b = 0; b < 4; b++) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("dbg_blank", int'(dbg_bin), 0);
      end
    end
  endtask

  task automatic drain(input string tag);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput(tag, q.size(), 0);
    q.delete();
  endtask

  initial begin
    rstn         = 1'b0;
    vsync        = 1'b0;
    de           = 1'b0;
    mask         = 1'b0;
    thresh       = 4'd0;
    model_thr    = 0;
    model_synced = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", int'(o_valid), 0);
    checkOutput("rst_bin", int'(o_bin), 0);
    checkOutput("rst_bx", int'(o_bx), 0);
    checkOutput("rst_by", int'(o_by), 0);
    checkOutput("rst_eof", int'(o_eof), 0);
    checkOutput("rst_dbg", int'(dbg_bin), 0);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] frame without vsync after reset");
    genMask(0);
    driveFrame(0, 4'd4, 4'd4, -1, -1, 1'b0);
    drain("drain_unsynced");

    $display("[TB] all ones, thresh 4");
    driveFrame(1, 4'd4, 4'd4, -1, -1, 1'b0);
    drain("drain_ones");

    $display("[TB] left column only, thresh 8");
    genMask(1);
    driveFrame(1, 4'd8, 4'd8, -1, -1, 1'b0);
    drain("drain_col0");

    $display("[TB] five-pixel block, thresh 5 then 6 with mid-frame change");
    genMask(2);
    driveFrame(1, 4'd5, 4'd5, -1, -1, 1'b0);
    drain("drain_thr5");
    driveFrame(1, 4'd6, 4'd0, -1, -1, 1'b0);
    drain("drain_thr6");

    $display("[TB] empty frame, thresh 0");
    genMask(3);
    driveFrame(1, 4'd0, 4'd0, -1, -1, 1'b0);
    drain("drain_thr0");

    $display("[TB] abort on line 3, then alternating rows");
    genMask(0);
    driveFrame(1, 4'd4, 4'd4, 3, 5, 1'b0);
    checkOutput("abort_pending", q.size(), 0);
    genMask(4);
    driveFrame(2, 4'd4, 4'd4, -1, -1, 1'b0);
    drain("drain_alt");

    $display("[TB] single block set, debug overlay");
    genMask(5);
    driveFrame(1, 4'd8, 4'd8, -1, -1, 1'b1);
    drain("drain_dbg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_block_compress.md
Name: bin_block_compress

Overview:
- Parametrised successor to the fixed 16x5 window compressor.
- Reduces a per-pixel binary mask stream (one bit per active pixel, HDMI timing) to a BLK_W x BLK_H block bitmap: counts the set bits in each block, compares the count against a runtime threshold, and emits one bin per block with its block coordinates.
- Sits between the mask generator and the bin buffer / target-search logic.
- Also drives an upscaled debug bit for HDMI overlay.

Parameters:
- H_ACT, 1280, active pixels per line
- V_ACT, 720, active lines per frame
- BLK_W, 32, block width in pixels (>=2)
- BLK_H, 10, block height in lines (>=1)
- COLS, H_ACT/BLK_W, blocks per line (derived, localparam)
- ROWS, V_ACT/BLK_H, block rows per frame (derived, localparam)
- SUM_W, $clog2(BLK_W*BLK_H+1), block count width (derived, localparam)

Ports:
- clk  in  1  pixel clock
- rstn  in  1  reset
- vsync  in  1  frame sync, active high; synchronous frame clear
- de  in  1  active-pixel strobe
- mask  in  1  pixel mask bit, valid when de=1
- thresh  in  SUM_W  bin threshold; latched while vsync=1
- o_valid  out  1  one-cycle pulse per completed block
- o_bin  out  1  1 when block count >= latched threshold
- o_bx  out  $clog2(COLS)  block column of the output
- o_by  out  $clog2(ROWS)  block row of the output
- o_eof  out  1  with o_valid, marks the last block (COLS-1, ROWS-1)
- dbg_bin  out  1  upscaled bitmap bit for overlay, 1 cycle behind de

Behaviour:
- Reset rstn: asynchronous, active-low; clock clk.
- Reset values: all outputs 0, all counters 0, synced=0, thr_q=0, partial-sum RAM and debug line contents don't-care.
- Frame gating:
  - synced is set by the first vsync after reset.
  - While synced=0, o_valid is suppressed.
- vsync=1:
  - Synchronously clears px, bx, py, by, acc and the de edge detector.
  - Latches thr_q<=thresh.
  - Has priority over de: a pixel coinciding with vsync is discarded.
- Counters:
  - px advances on de; at BLK_W-1 it wraps to 0 and bx++.
  - de falling edge (de_d & ~de): px, bx, acc := 0; py++.
  - py at BLK_H-1 wraps to 0 and by++.
- Overflow pixels/lines:
  - Pixels with bx>=COLS are ignored; bx saturates at COLS.
  - Lines with by>=ROWS are ignored (no outputs, no RAM writes).
- Accumulation:
  - acc (SUM_W bits) += mask on each in-range pixel.
  - At px==BLK_W-1: tot = acc + mask + (py==0 ? 0 : psum[bx]); then acc := 0.
  - If py<BLK_H-1: psum[bx] := tot.
  - Else: the block completes.
  - tot never exceeds BLK_W*BLK_H, so there is no overflow.
- Output (registered; latency 1 clk after the last pixel of the block):
  - o_valid=1, o_bin=(tot>=thr_q), o_bx=bx, o_by=by.
  - o_eof=(bx==COLS-1 && by==ROWS-1).
  - In all other cycles o_valid=0 and o_eof=0; o_bin, o_bx and o_by hold their last values.
- thresh=0 forces every bin to 1.
- Partial-sum RAM:
  - COLS x SUM_W, one write per block-column per line, combinational read at the same index.
  - The py==0 bypass makes stale content harmless after reset or vsync abort.
- Debug path:
  - dbg_line[COLS] is written with o_bin at o_valid.
  - On each de cycle: dbg_bin <= dbg_line[min(bx,COLS-1)].
  - Outside de: dbg_bin <= 0.
  - Effective behaviour: block row r displays the bins of row r-1, except that already-completed columns of row r's last line display row r.
- Mid-frame vsync aborts the current frame: no further outputs until new blocks complete; no partial flush.
- Mid-frame reset: everything clears and synced=0, so output waits for the next vsync.

Decomposition:
- Package compress_pkg:
  - function sum_width(bw,bh).
  - Default H_ACT/V_ACT/BLK_W/BLK_H constants.
  - typedef struct bin_out_t {bin, bx, by, eof} for downstream consumers.
- Sub-module bin_psum_ram: COLS-deep, SUM_W-wide register array with synchronous write and asynchronous read.
  - Isolated so it can be mapped to distributed RAM.
- Counters, threshold logic and debug line stay in the top-level.

Test Plan:
All scenarios use H_ACT=16, V_ACT=8, BLK_W=4, BLK_H=2 (COLS=4, ROWS=4, SUM_W=4).
- All-ones mask, thresh=4 -> 16 o_valid pulses per frame, all o_bin=1; (bx,by) follow raster order (0,0)..(3,3); o_eof only on (3,3); each pulse 1 clk after pixel x=4*bx+3 on line 2*by+1.
- mask=1 only for x<4, thresh=8 -> bx=0 gives o_bin=1 (count 8); bx=1..3 give o_bin=0 (count 0).
- Threshold boundary: a block with exactly 5 set pixels gives o_bin=1 with thresh=5 and o_bin=0 with thresh=6. With thresh=0, an all-zero frame still gives all bins=1. Changing thresh mid-frame has no effect until the next vsync.
- After rstn release with no vsync, a full frame of de/mask=1 -> no o_valid. After one vsync, the next frame behaves normally.
- vsync asserted on line 3 mid-frame, followed by a fresh frame with alternating-row masks (even lines 1s, odd lines 0s), thresh=4 -> counts are 4 and all bins=1. No stale partial sums leak; the pixel concurrent with vsync is dropped.
- Frame with block (0,0) bin=1 and others 0 -> on lines 2..3, dbg_bin=1 exactly for x=0..3 (1 clk delayed) and 0 elsewhere. dbg_bin=0 whenever de=0.
